// File: rtl/arm_regfile_sb_if.sv
// Decode-side register file bus: write-back commit, two read ports,
// issue request and scoreboard hazard outputs.
interface arm_regfile_sb_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
);
    logic             we3;
    logic [AW-1:0]    wa3;
    logic [WIDTH-1:0] wd3;
    logic [AW-1:0]    ra1;
    logic [AW-1:0]    ra2;
    logic [WIDTH-1:0] r15;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic             use1;
    logic             use2;
    logic             issue_en;
    logic [AW-1:0]    issue_wa;
    logic             stall;
    logic [14:0]      pending;

    modport master (
        output we3, wa3, wd3, ra1, ra2, r15,
        output use1, use2, issue_en, issue_wa,
        input  rd1, rd2, stall, pending
    );

    modport slave (
        input  we3, wa3, wd3, ra1, ra2, r15,
        input  use1, use2, issue_en, issue_wa,
        output rd1, rd2, stall, pending
    );
endinterface

// File: rtl/arm_regfile_sb.sv
// ARM register file R0-R14 with write-through bypass and a
// pending-write scoreboard that stalls decode on RAW/WAW hazards.
module arm_regfile_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 4
) (
    input logic              clk,
    input logic              reset,
    arm_regfile_sb_if.slave  rf
);
    localparam logic [AW-1:0] PC = AW'(15);

    logic [WIDTH-1:0] regs [15];
    logic [14:0]      pending_q;
    logic [14:0]      pending_d;
    logic [15:0]      pend_ext;
    logic             wb_ok;
    logic             busy1;
    logic             busy2;
    logic             busy3;
    logic             stall_c;

    // Bit 15 is a constant zero so that busy(PC) is never set.
    assign pend_ext = {1'b0, pending_q};
    assign wb_ok    = rf.we3 && (rf.wa3 != PC);

    function automatic logic busy(
        input logic [AW-1:0] x,
        input logic [15:0]   p,
        input logic          hit_en,
        input logic [AW-1:0] wa
    );
        return p[x] && !(hit_en && (wa == x));
    endfunction

    function automatic logic [WIDTH-1:0] rd_sel(
        input logic [AW-1:0]    ra,
        input logic [WIDTH-1:0] stored
    );
        if (ra == PC)
            return rf.r15;
        else if (rf.we3 && (rf.wa3 == ra))
            return rf.wd3;
        else
            return stored;
    endfunction

    assign rf.rd1 = rd_sel(rf.ra1, regs[rf.ra1]);
    assign rf.rd2 = rd_sel(rf.ra2, regs[rf.ra2]);

    assign busy1 = busy(rf.ra1, pend_ext, wb_ok, rf.wa3);
    assign busy2 = busy(rf.ra2, pend_ext, wb_ok, rf.wa3);
    assign busy3 = busy(rf.issue_wa, pend_ext, wb_ok, rf.wa3);

    assign stall_c = (rf.use1 && busy1)
                  || (rf.use2 && busy2)
                  || (rf.issue_en && busy3);

    assign rf.stall   = stall_c;
    assign rf.pending = pending_q;

    // Set after clear: a same-cycle write-back and re-issue stays pending.
    always_comb begin
        pending_d = pending_q;
        if (wb_ok)
            pending_d[rf.wa3] = 1'b0;
        if (rf.issue_en && !stall_c && (rf.issue_wa != PC))
            pending_d[rf.issue_wa] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++)
                regs[i] <= '0;
            pending_q <= '0;
        end else begin
            if (wb_ok)
                regs[rf.wa3] <= rf.wd3;
            pending_q <= pending_d;
        end
    end
endmodule

// File: tb/tb_arm_regfile_sb.sv
// Randomized and directed bench for arm_regfile_sb against an
// array-based reference model of registers and pending writes.
module tb_arm_regfile_sb;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    arm_regfile_sb_if bus ();

    arm_regfile_sb dut (
        .clk   (clk),
        .reset (reset),
        .rf    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mr [15];
    logic [14:0] mp;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_rd(logic [3:0] a);
        if (a == 4'd15)
            return bus.r15;
        if (bus.we3 && bus.wa3 == a)
            return bus.wd3;
        return mr[a];
    endfunction

    function automatic logic m_busy(logic [3:0] a);
        if (a == 4'd15)
            return 1'b0;
        return mp[a] && !(bus.we3 && bus.wa3 == a);
    endfunction

    function automatic logic m_stall();
        return (bus.use1 && m_busy(bus.ra1))
            || (bus.use2 && m_busy(bus.ra2))
            || (bus.issue_en && m_busy(bus.issue_wa));
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 15; i++)
            mr[i] = '0;
        mp = '0;
    endtask

    task automatic idle();
        bus.we3      = 1'b0;
        bus.wa3      = '0;
        bus.wd3      = '0;
        bus.ra1      = '0;
        bus.ra2      = '0;
        bus.r15      = '0;
        bus.use1     = 1'b0;
        bus.use2     = 1'b0;
        bus.issue_en = 1'b0;
        bus.issue_wa = '0;
    endtask

    task automatic comb_check(string t);
        check({t, ".rd1"}, bus.rd1, m_rd(bus.ra1));
        check({t, ".rd2"}, bus.rd2, m_rd(bus.ra2));
        check({t, ".stall"}, {31'd0, bus.stall}, {31'd0, m_stall()});
    endtask

    // Advance one edge, update the model from the pre-edge inputs.
    task automatic tick();
        logic s;
        s = m_stall();
        @(posedge clk);
        if (reset) begin
            m_clear();
        end else begin
            if (bus.we3 && bus.wa3 != 4'd15) begin
                mr[bus.wa3] = bus.wd3;
                mp[bus.wa3] = 1'b0;
            end
            if (bus.issue_en && !s && bus.issue_wa != 4'd15)
                mp[bus.issue_wa] = 1'b1;
        end
        #1;
        check("pending", {17'd0, bus.pending}, {17'd0, mp});
    endtask

    task automatic issue(logic [3:0] a);
        @(negedge clk);
        idle();
        bus.issue_en = 1'b1;
        bus.issue_wa = a;
        tick();
    endtask

    task automatic wback(logic [3:0] a, logic [31:0] d);
        @(negedge clk);
        idle();
        bus.we3 = 1'b1;
        bus.wa3 = a;
        bus.wd3 = d;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        m_clear();
        #2;
        reset = 1'b1;
        bus.ra1 = 4'd3;
        bus.ra2 = 4'd15;
        bus.r15 = 32'h0000_0108;
        #2;
        check("rst.rd1", bus.rd1, 32'h0);
        check("rst.rd2", bus.rd2, 32'h0000_0108);
        check("rst.stall", {31'd0, bus.stall}, 32'd0);
        check("rst.pending", {17'd0, bus.pending}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // commit and bypass
        @(negedge clk);
        idle();
        bus.we3 = 1'b1;
        bus.wa3 = 4'd5;
        bus.wd3 = 32'hDEAD_BEEF;
        bus.ra1 = 4'd5;
        #1;
        check("bypass.rd1", bus.rd1, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        bus.we3 = 1'b0;
        #1;
        check("commit.rd1", bus.rd1, 32'hDEAD_BEEF);
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.wa3 = 4'd15;
        bus.wd3 = 32'h1234_5678;
        bus.ra2 = 4'd15;
        bus.r15 = 32'h0000_0200;
        #1;
        comb_check("wr15");
        check("wr15.rd2", bus.rd2, 32'h0000_0200);
        tick();
        @(negedge clk);
        idle();
        bus.ra1 = 4'd5;
        #1;
        check("wr15.r5", bus.rd1, 32'hDEAD_BEEF);
        check("wr15.pending", {17'd0, bus.pending}, 32'd0);

        // RAW
        issue(4'd2);
        check("raw.set", {17'd0, bus.pending}, 32'h4);
        @(negedge clk);
        idle();
        bus.use1 = 1'b1;
        bus.ra1  = 4'd2;
        #1;
        check("raw.stall", {31'd0, bus.stall}, 32'd1);
        tick();
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.wa3 = 4'd2;
        bus.wd3 = 32'd7;
        #1;
        check("raw.release", {31'd0, bus.stall}, 32'd0);
        check("raw.rd1", bus.rd1, 32'd7);
        tick();
        check("raw.clear", {17'd0, bus.pending}, 32'd0);

        // WAW
        issue(4'd4);
        @(negedge clk);
        idle();
        bus.issue_en = 1'b1;
        bus.issue_wa = 4'd4;
        #1;
        check("waw.stall", {31'd0, bus.stall}, 32'd1);
        tick();
        check("waw.hold", {17'd0, bus.pending}, 32'h10);
        @(negedge clk);
        bus.we3 = 1'b1;
        bus.wa3 = 4'd4;
        bus.wd3 = 32'd9;
        #1;
        check("waw.go", {31'd0, bus.stall}, 32'd0);
        tick();
        check("waw.setwins", {17'd0, bus.pending}, 32'h10);

        // unused operand
        issue(4'd6);
        @(negedge clk);
        idle();
        bus.ra2 = 4'd6;
        #1;
        check("unused.stall", {31'd0, bus.stall}, 32'd0);
        bus.use2 = 1'b1;
        #1;
        check("used.stall", {31'd0, bus.stall}, 32'd1);

        // reset mid-operation
        wback(4'd4, 32'd1);
        wback(4'd6, 32'd2);
        issue(4'd1);
        issue(4'd3);
        check("mid.pend", {17'd0, bus.pending}, 32'hA);
        @(negedge clk);
        idle();
        bus.issue_en = 1'b1;
        bus.issue_wa = 4'd8;
        #1;
        reset = 1'b1;
        #1;
        check("mid.async", {17'd0, bus.pending}, 32'd0);
        tick();
        @(negedge clk);
        reset = 1'b0;
        idle();
        tick();
        check("mid.r8", {31'd0, bus.pending[8]}, 32'd0);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            bus.ra1 = 4'(i);
            #1;
            check("mid.reg", bus.rd1, 32'd0);
        end

        // random traffic
        repeat (400) begin
            @(negedge clk);
            bus.we3      = 1'($urandom_range(0, 1));
            bus.wa3      = 4'($urandom_range(0, 15));
            bus.wd3      = $urandom;
            bus.ra1      = 4'($urandom_range(0, 15));
            bus.ra2      = 4'($urandom_range(0, 15));
            bus.r15      = $urandom;
            bus.use1     = 1'($urandom_range(0, 1));
            bus.use2     = 1'($urandom_range(0, 1));
            bus.issue_en = 1'($urandom_range(0, 1));
            bus.issue_wa = 4'($urandom_range(0, 15));
            #1;
            comb_check("rand");
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arm_regfile_sb.md
# arm_regfile_sb

Register file with a write-back pending-write scoreboard for the pipelined ARM core. It sits at the decode stage. It is the receiving end of the write-back pipeline register: that register delivers the 32-bit result and 4-bit destination index, which this block commits to R0–R14. Decode reads two operands here. The scoreboard tracks every destination issued but not yet written back and raises a stall when a read, or a new write, depends on one.

## Interface
Parameters:
- WIDTH, 32, data width of every register and data port
- AW, 4, register index width (16 architectural indices; index 15 = PC)

Ports (reset is asynchronous, active-high, named reset; the clock is clk):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all registers and scoreboard
- we3  in  1  write-back enable from write-back pipeline register
- wa3  in  AW  write-back destination index
- wd3  in  WIDTH  write-back data
- ra1  in  AW  read port 1 index
- ra2  in  AW  read port 2 index
- r15  in  WIDTH  PC+8 value supplied by fetch; returned for index 15
- rd1  out  WIDTH  read port 1 data (combinational)
- rd2  out  WIDTH  read port 2 data (combinational)
- use1  in  1  decoded instruction consumes ra1
- use2  in  1  decoded instruction consumes ra2
- issue_en  in  1  decoded instruction writes a register and wants to advance
- issue_wa  in  AW  destination index of the issuing instruction
- stall  out  1  decode must hold (combinational)
- pending  out  15  scoreboard bits for R14..R0 (registered, debug/hazard visibility)

## Operation
- Storage: 15 registers, R0–R14, each WIDTH bits. Index 15 is never stored. Writes to 15 are ignored and never touch the scoreboard.
- Commit: at rising clk, if we3 && wa3 != 15, then R[wa3] <= wd3.
- Read: rdN = r15 if raN == 15. Otherwise rdN = wd3 if we3 && wa3 == raN (write-through bypass). Otherwise rdN = R[raN].
- Define wbhit(x) = we3 && wa3 == x && x != 15.
- Define busy(x) = pending[x] && !wbhit(x). busy(15) = 0.
- stall = (use1 && busy(ra1)) || (use2 && busy(ra2)) || (issue_en && busy(issue_wa)).
  - The last term blocks a second outstanding write to the same register (WAW); each pending bit tracks at most one write.
- Scoreboard update, at rising clk, in this order:
  1. if wbhit(wa3): clear pending[wa3]
  2. if issue_en && !stall && issue_wa != 15: set pending[issue_wa]
- The set is applied after the clear, so set wins when both hit the same index in the same cycle.
- A write-back to an index that is not pending is legal: data commits and the bit stays 0.
- Reset: all R0–R14 = 0, pending = 0. Therefore rd1/rd2 = 0 for indices 0–14, r15 for index 15, and stall = 0.

## Timing
- Read path: fully combinational from ra1/ra2/r15/we3/wa3/wd3 to rd1/rd2. Zero-cycle bypass: a write is visible on the read ports in the same cycle it is presented.
- Commit latency: R[wa3] holds the new value from the edge after we3 onward.
- stall is combinational from ra*/use*/issue_*/we3/wa3 and the registered pending bits. It depends on no other stall.
- pending changes only on rising clk, or immediately on reset assertion.
- Reset mid-operation: an in-flight issue or write-back in the reset cycle is discarded. The first edge after deassertion behaves normally.
- Worst case: a read hazard stalls until the cycle the matching write-back appears on we3/wa3. The stall drops in that same cycle, and bypass supplies the data.

## Test plan
- Reset then read: assert reset, write nothing, ra1=3, ra2=15, r15=0x0000_0108 -> rd1=0, rd2=0x0000_0108, stall=0, pending=0.
- Commit and bypass: we3=1, wa3=5, wd3=0xDEAD_BEEF, ra1=5 -> rd1=0xDEAD_BEEF in the same cycle. Next cycle, with we3=0, rd1 still 0xDEAD_BEEF. A write with wa3=15 leaves every register and pending unchanged.
- RAW stall: issue_en=1, issue_wa=2 -> pending[2]=1 after the edge. Next cycle use1=1, ra1=2, we3=0 -> stall=1. Cycle with we3=1, wa3=2, wd3=7 -> stall=0, rd1=7, and pending[2]=0 after the edge.
- WAW block: pending[4]=1, issue_en=1, issue_wa=4, we3=0 -> stall=1 and pending unchanged. Same issue with we3=1, wa3=4 -> stall=0, and pending[4]=1 after the edge (set wins).
- Unused operand: pending[6]=1, ra2=6, use2=0, issue_en=0 -> stall=0.
- Reset mid-operation: pending={R1,R3} set, then reset pulses during an issue to R8 -> pending=0, all registers 0, and R8 not pending after deassertion.
